// File: rtl/ahb_arb_pkg.sv
// Shared encodings and types for the two-master AHB-Lite arbiter.
// Used by ahb_arb_grant_sel and ahb_lite_arbiter_2m.
package ahb_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_PARK = 2'd0,
        ST_M0   = 2'd1,
        ST_M1   = 2'd2
    } arb_state_e;

    typedef logic master_id_t;

    // True for transfer types that move data (NONSEQ or SEQ).
    function automatic logic trans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_arb_grant_sel.sv
// Combinational next-grant decision for the two-master arbiter.
// Optional macro AHB_ARB_FIXED_PRIO_EN selects fixed M0 priority instead of round robin.
module ahb_arb_grant_sel
    import ahb_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
)
(
    input  logic       req0,
    input  logic       req1,
    input  logic       owned,
    input  logic       owner,
    input  logic [7:0] hold_cnt,
    input  logic       last_win,
    output logic       next_park,
    output logic       next_win
);

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

    logic hold_ok;
    assign hold_ok = owned && (hold_cnt < HOLD_LIM);

`ifdef AHB_ARB_FIXED_PRIO_EN
    logic unused_last_win;
    assign unused_last_win = last_win;
`endif

    // Pick park / winner from the current request pattern.
    always_comb begin
        next_park = 1'b0;
        next_win  = owner;
        case ({req1, req0})
            2'b00: begin
                next_park = 1'b1;
                next_win  = owner;
            end
            2'b01: next_win = 1'b0;
            2'b10: next_win = 1'b1;
            2'b11: begin
`ifdef AHB_ARB_FIXED_PRIO_EN
                // M0 yields only once M1 has waited out a full hold window.
                if (owned && !owner && !hold_ok) begin
                    next_win = 1'b1;
                end else begin
                    next_win = 1'b0;
                end
`else
                if (hold_ok) begin
                    next_win = owner;
                end else begin
                    next_win = ~last_win;
                end
`endif
            end
            default: begin
                next_park = 1'b1;
                next_win  = owner;
            end
        endcase
    end

endmodule

// File: rtl/ahb_lite_arbiter_2m.sv
// Two-master AHB-Lite arbiter and bus mux with lock support and hold-limit re-arbitration.
// Optional macro AHB_ARB_FIXED_PRIO_EN (see ahb_arb_grant_sel) selects fixed priority.
module ahb_lite_arbiter_2m
    import ahb_arb_pkg::*;
#(
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_HOLD       = 16
)
(
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        M0_HBUSREQ,
    input  logic        M0_HLOCK,
    output logic        M0_HGRANT,
    input  logic [31:0] M0_HADDR,
    input  logic [1:0]  M0_HTRANS,
    input  logic        M0_HWRITE,
    input  logic [2:0]  M0_HSIZE,
    input  logic [2:0]  M0_HBURST,
    input  logic [3:0]  M0_HPROT,
    input  logic [31:0] M0_HWDATA,
    output logic [31:0] M0_HRDATA,
    output logic        M0_HREADY,
    output logic        M0_HRESP,
    input  logic        M1_HBUSREQ,
    input  logic        M1_HLOCK,
    output logic        M1_HGRANT,
    input  logic [31:0] M1_HADDR,
    input  logic [1:0]  M1_HTRANS,
    input  logic        M1_HWRITE,
    input  logic [2:0]  M1_HSIZE,
    input  logic [2:0]  M1_HBURST,
    input  logic [3:0]  M1_HPROT,
    input  logic [31:0] M1_HWDATA,
    output logic [31:0] M1_HRDATA,
    output logic        M1_HREADY,
    output logic        M1_HRESP,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    output logic        HMASTLOCK,
    output logic        HMASTER,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    input  logic        HRESP
);

    localparam master_id_t DEF_M = DEFAULT_MASTER[0];

    arb_state_e state;
    arb_state_e sel_state;
    master_id_t gnt;
    master_id_t addr_owner;
    master_id_t data_owner;
    master_id_t last_win;
    logic       lock_q;
    logic [7:0] hold_cnt;
    logic       own_lock;
    logic       own_active;
    logic       arb_pt;
    logic       sel_park;
    logic       sel_win;

    // Grant decodes straight from the state register.
    always_comb begin
        case (state)
            ST_M0:   gnt = 1'b0;
            ST_M1:   gnt = 1'b1;
            default: gnt = DEF_M;
        endcase
    end

    assign M0_HGRANT  = (gnt == 1'b0);
    assign M1_HGRANT  = (gnt == 1'b1);
    assign own_lock   = gnt ? M1_HLOCK : M0_HLOCK;
    assign own_active = trans_active(gnt ? M1_HTRANS : M0_HTRANS);
    // A locked sequence stays atomic until its last data phase has drained.
    assign arb_pt     = HREADY && !own_lock && !lock_q;

    ahb_arb_grant_sel #(
        .MAX_HOLD (MAX_HOLD)
    ) u_grant_sel (
        .req0      (M0_HBUSREQ),
        .req1      (M1_HBUSREQ),
        .owned     (state != ST_PARK),
        .owner     (gnt),
        .hold_cnt  (hold_cnt),
        .last_win  (last_win),
        .next_park (sel_park),
        .next_win  (sel_win)
    );

    // Map the selector result back onto a state encoding.
    always_comb begin
        if (sel_park) begin
            sel_state = ST_PARK;
        end else if (sel_win) begin
            sel_state = ST_M1;
        end else begin
            sel_state = ST_M0;
        end
    end

    // Arbitration state, ownership pipeline and hold counter.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= ST_PARK;
            addr_owner <= DEF_M;
            data_owner <= DEF_M;
            lock_q     <= 1'b0;
            hold_cnt   <= 8'd0;
            last_win   <= 1'b1;
        end else begin
            if (HREADY) begin
                addr_owner <= gnt;
                data_owner <= addr_owner;
                lock_q     <= own_lock;
            end
            if (arb_pt && (sel_state != state)) begin
                state    <= sel_state;
                hold_cnt <= 8'd0;
                if (sel_state != ST_PARK) begin
                    last_win <= sel_win;
                end
            end else if (state == ST_PARK) begin
                hold_cnt <= 8'd0;
            end else if (HREADY && own_active && (hold_cnt != 8'hFF)) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end

    assign HADDR     = addr_owner ? M1_HADDR  : M0_HADDR;
    assign HTRANS    = addr_owner ? M1_HTRANS : M0_HTRANS;
    assign HWRITE    = addr_owner ? M1_HWRITE : M0_HWRITE;
    assign HSIZE     = addr_owner ? M1_HSIZE  : M0_HSIZE;
    assign HBURST    = addr_owner ? M1_HBURST : M0_HBURST;
    assign HPROT     = addr_owner ? M1_HPROT  : M0_HPROT;
    assign HWDATA    = data_owner ? M1_HWDATA : M0_HWDATA;
    assign HMASTER   = addr_owner;
    assign HMASTLOCK = lock_q;

    assign M0_HRDATA = HRDATA;
    assign M1_HRDATA = HRDATA;
    assign M0_HREADY = HREADY;
    assign M1_HREADY = HREADY;
    assign M0_HRESP  = HRESP;
    assign M1_HRESP  = HRESP;

endmodule

// File: tb/tb_ahb_lite_arbiter_2m.sv
// Directed self-checking bench for ahb_lite_arbiter_2m (DEFAULT_MASTER=0).
// With AHB_ARB_FIXED_PRIO_EN defined the priority sequence runs with MAX_HOLD=16.
module tb_ahb_lite_arbiter_2m;

`ifdef AHB_ARB_FIXED_PRIO_EN
    localparam int MAXH = 16;
`else
    localparam int MAXH = 4;
`endif

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        M0_HBUSREQ, M0_HLOCK, M0_HGRANT, M0_HWRITE, M0_HREADY, M0_HRESP;
    logic [31:0] M0_HADDR, M0_HWDATA, M0_HRDATA;
    logic [1:0]  M0_HTRANS;
    logic [2:0]  M0_HSIZE, M0_HBURST;
    logic [3:0]  M0_HPROT;
    logic        M1_HBUSREQ, M1_HLOCK, M1_HGRANT, M1_HWRITE, M1_HREADY, M1_HRESP;
    logic [31:0] M1_HADDR, M1_HWDATA, M1_HRDATA;
    logic [1:0]  M1_HTRANS;
    logic [2:0]  M1_HSIZE, M1_HBURST;
    logic [3:0]  M1_HPROT;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HMASTLOCK, HMASTER, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    ahb_lite_arbiter_2m #(
        .DEFAULT_MASTER (0),
        .MAX_HOLD       (MAXH)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .M0_HBUSREQ (M0_HBUSREQ),
        .M0_HLOCK   (M0_HLOCK),
        .M0_HGRANT  (M0_HGRANT),
        .M0_HADDR   (M0_HADDR),
        .M0_HTRANS  (M0_HTRANS),
        .M0_HWRITE  (M0_HWRITE),
        .M0_HSIZE   (M0_HSIZE),
        .M0_HBURST  (M0_HBURST),
        .M0_HPROT   (M0_HPROT),
        .M0_HWDATA  (M0_HWDATA),
        .M0_HRDATA  (M0_HRDATA),
        .M0_HREADY  (M0_HREADY),
        .M0_HRESP   (M0_HRESP),
        .M1_HBUSREQ (M1_HBUSREQ),
        .M1_HLOCK   (M1_HLOCK),
        .M1_HGRANT  (M1_HGRANT),
        .M1_HADDR   (M1_HADDR),
        .M1_HTRANS  (M1_HTRANS),
        .M1_HWRITE  (M1_HWRITE),
        .M1_HSIZE   (M1_HSIZE),
        .M1_HBURST  (M1_HBURST),
        .M1_HPROT   (M1_HPROT),
        .M1_HWDATA  (M1_HWDATA),
        .M1_HRDATA  (M1_HRDATA),
        .M1_HREADY  (M1_HREADY),
        .M1_HRESP   (M1_HRESP),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HBURST     (HBURST),
        .HPROT      (HPROT),
        .HWDATA     (HWDATA),
        .HMASTLOCK  (HMASTLOCK),
        .HMASTER    (HMASTER),
        .HREADY     (HREADY),
        .HRDATA     (HRDATA),
        .HRESP      (HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        HRESET     = 1'b1;
        M0_HBUSREQ = 1'b0; M0_HLOCK = 1'b0; M0_HTRANS = 2'd0; M0_HWRITE = 1'b0;
        M1_HBUSREQ = 1'b0; M1_HLOCK = 1'b0; M1_HTRANS = 2'd0; M1_HWRITE = 1'b0;
        M0_HADDR   = 32'h0000_1000; M1_HADDR = 32'h0000_2000;
        M0_HWDATA  = 32'h1111_1111; M1_HWDATA = 32'h2222_2222;
        M0_HSIZE   = 3'd2; M0_HBURST = 3'd0; M0_HPROT = 4'd3;
        M1_HSIZE   = 3'd2; M1_HBURST = 3'd0; M1_HPROT = 4'd3;
        HREADY     = 1'b1; HRESP = 1'b0; HRDATA = 32'h5555_AAAA;
        step();
        step();
        HRESET = 1'b0;
    endtask

    initial begin
        logic prev;
        logic exp_g;

        // Reset state: M0 parked, its IDLE visible on the slave bus.
        do_reset();
        M1_HTRANS = 2'd2;
        HRESP     = 1'b1;
        #1;
        chk("rst_m0_grant", 32'(M0_HGRANT), 32'd1);
        chk("rst_m1_grant", 32'(M1_HGRANT), 32'd0);
        chk("rst_hmaster", 32'(HMASTER), 32'd0);
        chk("rst_hmastlock", 32'(HMASTLOCK), 32'd0);
        chk("rst_htrans", 32'(HTRANS), 32'd0);
        chk("rst_haddr", HADDR, 32'h0000_1000);
        chk("rst_m1_hrdata", M1_HRDATA, 32'h5555_AAAA);
        chk("rst_m0_hresp", 32'(M0_HRESP), 32'd1);
        HRESP     = 1'b0;
        M1_HTRANS = 2'd0;

        // M1 alone: grant, address phase, then data phase.
        M1_HBUSREQ = 1'b1;
        step();
        chk("m1_grant", 32'(M1_HGRANT), 32'd1);
        chk("m1_m0_grant", 32'(M0_HGRANT), 32'd0);
        chk("m1_hmaster_lag", 32'(HMASTER), 32'd0);
        M1_HTRANS = 2'd2;
        M1_HWRITE = 1'b1;
        M1_HADDR  = 32'h0100_0004;
        step();
        chk("m1_haddr", HADDR, 32'h0100_0004);
        chk("m1_hmaster", 32'(HMASTER), 32'd1);
        chk("m1_htrans", 32'(HTRANS), 32'd2);
        chk("m1_hwrite", 32'(HWRITE), 32'd1);
        chk("m1_hwdata_old", HWDATA, 32'h1111_1111);
        M1_HWDATA  = 32'hA5A5_5A5A;
        M1_HTRANS  = 2'd0;
        M1_HBUSREQ = 1'b0;
        step();
        chk("m1_hwdata", HWDATA, 32'hA5A5_5A5A);
        chk("m1_hmaster_data", 32'(HMASTER), 32'd1);
        chk("m1_release_park", 32'(M0_HGRANT), 32'd1);

        // Wait states during a pending ownership change.
        do_reset();
        M1_HBUSREQ = 1'b1;
        step();
        chk("ws_grant", 32'(M1_HGRANT), 32'd1);
        HREADY     = 1'b0;
        HRESP      = 1'b1;
        M1_HBUSREQ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ws_hmaster_hold", 32'(HMASTER), 32'd0);
            chk("ws_hwdata_hold", HWDATA, 32'h1111_1111);
            chk("ws_grant_hold", 32'(M1_HGRANT), 32'd1);
            chk("ws_m0_hready", 32'(M0_HREADY), 32'd0);
        end
        HREADY     = 1'b1;
        HRESP      = 1'b0;
        M1_HBUSREQ = 1'b1;
        step();
        chk("ws_hmaster_new", 32'(HMASTER), 32'd1);
        chk("ws_hwdata_old", HWDATA, 32'h1111_1111);
        step();
        chk("ws_hwdata_new", HWDATA, 32'h2222_2222);

        // Both masters request continuously with back-to-back transfers.
        do_reset();
        M0_HBUSREQ = 1'b1; M1_HBUSREQ = 1'b1;
        M0_HTRANS  = 2'd2; M1_HTRANS  = 2'd2;
        prev = 1'b0;
`ifdef AHB_ARB_FIXED_PRIO_EN
        for (int k = 1; k <= 18; k++) begin
            step();
            exp_g = (k == 17);
            chk("fp_m1_grant", 32'(M1_HGRANT), 32'(exp_g));
            chk("fp_hmaster", 32'(HMASTER), 32'(prev));
            prev = exp_g;
        end
`else
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_g = (((k - 1) / 4) % 2) == 1;
            chk("rr_m1_grant", 32'(M1_HGRANT), 32'(exp_g));
            chk("rr_hmaster", 32'(HMASTER), 32'(prev));
            prev = exp_g;
        end
`endif

        // Locked 8-beat burst from M0 with M1 waiting.
        do_reset();
        M0_HBUSREQ = 1'b1;
        step();
        chk("lk_m0_grant", 32'(M0_HGRANT), 32'd1);
        M0_HLOCK   = 1'b1;
        M1_HBUSREQ = 1'b1;
        step();
        chk("lk_hmastlock_start", 32'(HMASTLOCK), 32'd1);
        chk("lk_m1_wait_start", 32'(M1_HGRANT), 32'd0);
        M0_HTRANS = 2'd2;
        for (int b = 2; b <= 8; b++) begin
            step();
            chk("lk_hmastlock", 32'(HMASTLOCK), 32'd1);
            chk("lk_m1_wait", 32'(M1_HGRANT), 32'd0);
            M0_HTRANS = 2'd3;
            if (b == 8) begin
                M0_HLOCK   = 1'b0;
                M0_HBUSREQ = 1'b0;
            end
        end
        step();
        chk("lk_hmastlock_drop", 32'(HMASTLOCK), 32'd0);
        chk("lk_m1_still_wait", 32'(M1_HGRANT), 32'd0);
        M0_HTRANS = 2'd0;
        step();
        chk("lk_m1_granted", 32'(M1_HGRANT), 32'd1);
        chk("lk_hmaster_lag", 32'(HMASTER), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
